// File: rtl/mw_hazard_ctrl_if.sv
// Pipeline-side signals between the MW-stage hazard controller and the datapath.
// The master modport is the pipeline/datapath; the slave modport is the controller.
interface mw_hazard_ctrl_if;
   logic [4:0] Rs1E;
   logic [4:0] Rs2E;
   logic [4:0] RdMW;
   logic       RegWriteMW;
   logic [1:0] ResultSrcMW;
   logic       MemWriteMW;
   logic       PCSrcE;
   logic       dmem_ready;
   logic       dmem_req;
   logic       StallF;
   logic       StallD;
   logic       StallE;
   logic       StallMW;
   logic       FlushD;
   logic       FlushE;
   logic       ForwardAE;
   logic       ForwardBE;
   logic       mem_err;

   modport master (
      output Rs1E, Rs2E, RdMW, RegWriteMW, ResultSrcMW, MemWriteMW, PCSrcE, dmem_ready,
      input  dmem_req, StallF, StallD, StallE, StallMW, FlushD, FlushE,
             ForwardAE, ForwardBE, mem_err
   );

   modport slave (
      input  Rs1E, Rs2E, RdMW, RegWriteMW, ResultSrcMW, MemWriteMW, PCSrcE, dmem_ready,
      output dmem_req, StallF, StallD, StallE, StallMW, FlushD, FlushE,
             ForwardAE, ForwardBE, mem_err
   );
endinterface

// File: rtl/mw_hazard_ctrl.sv
// Stall/flush/forward controller for a 4-stage RV32I pipeline with a memory-wait watchdog.
// HAZARD_PERF_EN adds stall_cycles / flush_count performance counters.
module mw_hazard_ctrl #(
   parameter int unsigned MAX_WAIT = 16
) (
   input  logic            clk,
   input  logic            reset_n,
   mw_hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0]     stall_cycles,
   output logic [15:0]     flush_count
`endif
);
   localparam int unsigned CW = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ERR  = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] wait_cnt_q, wait_cnt_d;
   logic          mem_err_q, mem_err_d;
   logic          mem_op;
   logic          mem_stall;
   logic          req_raw;
   logic          flush_raw;

   assign mem_op = hz.MemWriteMW | (hz.ResultSrcMW == 2'b01);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         wait_cnt_q <= '0;
         mem_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         mem_err_q  <= mem_err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      mem_err_d  = mem_err_q;
      mem_stall  = 1'b0;
      req_raw    = 1'b0;
      unique case (state_q)
         IDLE: begin
            req_raw   = mem_op;
            mem_stall = mem_op & ~hz.dmem_ready;
            if (mem_op && !hz.dmem_ready) begin
               state_d    = WAIT;
               wait_cnt_d = CW'(1);
            end
         end
         WAIT: begin
            req_raw   = mem_op;
            mem_stall = ~hz.dmem_ready;
            // Ready at the watchdog limit still completes the access.
            if (hz.dmem_ready) begin
               state_d    = IDLE;
               wait_cnt_d = '0;
            end else if (wait_cnt_q == CW'(MAX_WAIT)) begin
               state_d   = ERR;
               mem_err_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + CW'(1);
            end
         end
         ERR: begin
            mem_stall = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign flush_raw = hz.PCSrcE & ~mem_stall;

   // Reset overrides every output, including the combinational terms.
   always_comb begin
      hz.dmem_req  = 1'b0;
      hz.StallF    = 1'b0;
      hz.StallD    = 1'b0;
      hz.StallE    = 1'b0;
      hz.StallMW   = 1'b0;
      hz.FlushD    = 1'b0;
      hz.FlushE    = 1'b0;
      hz.ForwardAE = 1'b0;
      hz.ForwardBE = 1'b0;
      hz.mem_err   = 1'b0;
      if (reset_n) begin
         hz.dmem_req  = req_raw;
         hz.StallF    = mem_stall;
         hz.StallD    = mem_stall;
         hz.StallE    = mem_stall;
         hz.StallMW   = mem_stall;
         hz.FlushD    = flush_raw;
         hz.FlushE    = flush_raw;
         hz.ForwardAE = hz.RegWriteMW & (hz.RdMW != 5'd0) & (hz.RdMW == hz.Rs1E);
         hz.ForwardBE = hz.RegWriteMW & (hz.RdMW != 5'd0) & (hz.RdMW == hz.Rs2E);
         hz.mem_err   = mem_err_q;
      end
   end

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [15:0] flush_count_q, flush_count_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_count_d  = flush_count_q;
      if (mem_stall && stall_cycles_q != 32'hFFFF_FFFF) begin
         stall_cycles_d = stall_cycles_q + 32'd1;
      end
      if (flush_raw) begin
         flush_count_d = flush_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         stall_cycles_q <= '0;
         flush_count_q  <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_count_q  <= flush_count_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;
`endif
endmodule
